gate_truth_sequencer: RTL and testbench



---
 rtl/gate_truth_sequencer.sv | 119 +++++++++++
 tb/tb_gate_truth_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_sequencer.sv
// Drives a 2-input gate through all four vectors, samples its output after
// a settle delay, and compares the sampled truth table with the expected one.
module gate_truth_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  input  logic       gate_out,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] fail_mask
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    exp_q, exp_d;
  logic [3:0]    res_q, res_d;
  logic [3:0]    fail_q, fail_d;
  logic          pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    res_d   = res_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          res_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          res_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          cnt_d        = '0;
          res_d[idx_q] = gate_out;
          if (idx_q == 2'd3) begin
            // Verdict folds in the vector-3 sample taken on this same edge
            pass_d  = (res_d == exp_q);
            fail_d  = res_d ^ exp_q;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == APPLY);
  assign done      = (state_q == DONE);
  assign gate_a    = busy & idx_q[1];
  assign gate_b    = busy & idx_q[0];
  assign pass      = pass_q;
  assign result    = res_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (settle 1 and 2) driven by
// a gate model, checked against a truth-table reference computed here.
module tb_gate_truth_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] expected;
  int         mode;

  logic       go   [2];
  logic       ga   [2];
  logic       gb   [2];
  logic       bsy  [2];
  logic       dn   [2];
  logic       ps   [2];
  logic [3:0] res  [2];
  logic [3:0] msk  [2];

  int total;
  int bad;

  function automatic logic gfn(input int m, input logic a, input logic b);
    case (m)
      0:       return a | b;
      1:       return 1'b0;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign go[g] = gfn(mode, ga[g], gb[g]);
    gate_truth_sequencer #(.SETTLE_CYCLES(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .expected  (expected),
      .gate_out  (go[g]),
      .gate_a    (ga[g]),
      .gate_b    (gb[g]),
      .busy      (bsy[g]),
      .done      (dn[g]),
      .pass      (ps[g]),
      .result    (res[g]),
      .fail_mask (msk[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [3:0] ref_table(input int m);
    logic [3:0] r;
    logic [1:0] vv;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      r[v] = gfn(m, vv[1], vv[0]);
    end
    return r;
  endfunction

  task automatic check_zero(input int s, input string nm);
    total++;
    if ({ga[s], gb[s], bsy[s], dn[s], ps[s]} !== 5'b0 ||
        res[s] !== 4'b0 || msk[s] !== 4'b0) begin
      bad++;
      $display("FAIL %s: a=%b b=%b busy=%b done=%b pass=%b res=%b mask=%b want all 0",
               nm, ga[s], gb[s], bsy[s], dn[s], ps[s], res[s], msk[s]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    expected = 4'b0;
    mode = 0;
    idle(2);
    rst_n = 1'b1;
    check_zero(0, "reset_s1");
    check_zero(1, "reset_s2");
    idle(1);
  endtask

  // One full run on instance s; optional re-start/expected change at E0+2
  task automatic run(input int s, input int m, input logic [3:0] ex,
                     input bit restart, input bit abort_too, input string nm);
    int S;
    logic [3:0] r;
    S = s + 1;
    mode = m;
    r = ref_table(m);
    expected = ex;
    start = 1'b1;
    abort = abort_too;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 4 * S; k++) begin
      total++;
      if (bsy[s] !== 1'b1 || dn[s] !== 1'b0 ||
          {ga[s], gb[s]} !== 2'(k / S)) begin
        bad++;
        $display("FAIL %s vec k=%0d: busy=%b done=%b ab=%b%b want busy=1 done=0 ab=%0d",
                 nm, k, bsy[s], dn[s], ga[s], gb[s], k / S);
      end
      if (restart && k == 1) begin
        start = 1'b1;
        expected = ~ex;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    total++;
    if (dn[s] !== 1'b1 || bsy[s] !== 1'b0 || {ga[s], gb[s]} !== 2'b00) begin
      bad++;
      $display("FAIL %s done_cycle: done=%b busy=%b ab=%b%b want done=1 busy=0 ab=00",
               nm, dn[s], bsy[s], ga[s], gb[s]);
    end
    total++;
    if (res[s] !== r) begin
      bad++;
      $display("FAIL %s result: got %b want %b", nm, res[s], r);
    end
    total++;
    if (ps[s] !== (r == ex)) begin
      bad++;
      $display("FAIL %s pass: got %b want %b", nm, ps[s], r == ex);
    end
    total++;
    if (msk[s] !== (r ^ ex)) begin
      bad++;
      $display("FAIL %s fail_mask: got %b want %b", nm, msk[s], r ^ ex);
    end
    tick();
    total++;
    if (dn[s] !== 1'b0 || res[s] !== r || ps[s] !== (r == ex)) begin
      bad++;
      $display("FAIL %s hold: done=%b res=%b pass=%b want done=0 res=%b pass=%b",
               nm, dn[s], res[s], ps[s], r, r == ex);
    end
    idle(10);
  endtask

  task automatic test_abort();
    mode = 0;
    expected = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if ({ga[1], gb[1]} !== 2'b10) begin
      bad++;
      $display("FAIL abort_pre: ab=%b%b want 10", ga[1], gb[1]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_zero(1, "abort_after");
    for (int k = 0; k < 10; k++) begin
      total++;
      if (dn[1] !== 1'b0 || bsy[1] !== 1'b0) begin
        bad++;
        $display("FAIL abort_nodone k=%0d: done=%b busy=%b want 0 0", k, dn[1], bsy[1]);
      end
      tick();
    end
    run(1, 0, 4'b1110, 1'b0, 1'b0, "abort_rerun");
  endtask

  task automatic test_mid_reset();
    mode = 0;
    expected = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) tick();
    total++;
    if ({ga[1], gb[1]} !== 2'b01) begin
      bad++;
      $display("FAIL rst_pre: ab=%b%b want 01", ga[1], gb[1]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero(1, "rst_after");
    for (int k = 0; k < 12; k++) begin
      total++;
      if (dn[1] !== 1'b0 || bsy[1] !== 1'b0) begin
        bad++;
        $display("FAIL rst_nodone k=%0d: done=%b busy=%b want 0 0", k, dn[1], bsy[1]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int s;
    int m;
    logic [3:0] ex;
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(1, 0));
      m = int'($urandom_range(3, 0));
      ex = 4'($urandom);
      run(s, m, ex, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    run(1, 0, 4'b1110, 1'b0, 1'b0, "or_pass");
    run(1, 0, 4'b1000, 1'b0, 1'b0, "or_vs_and");
    run(1, 1, 4'b1110, 1'b0, 1'b0, "stuck0");
    run(0, 0, 4'b1110, 1'b1, 1'b0, "s1_restart");
    run(0, 0, 4'b1110, 1'b0, 1'b1, "start_abort_idle");
    test_abort();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
